// File: rtl/bcd_to_binary_seq.sv
// Sequential 4-digit BCD to 16-bit binary converter (reverse double-dabble).
// One bit is shifted out per clock; 16 iterations per conversion, with an early exit for bad digits.
module bcd_to_binary_seq #(
  parameter bit CHECK_DIGITS = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  D4,
  input  logic [3:0]  hundreds,
  input  logic [3:0]  tens,
  input  logic [3:0]  ones,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] binary
);

  // state   | meaning
  // S_IDLE  | waiting for start
  // S_LOAD  | invalid digit seen at accept, reporting the error next edge
  // S_SHIFT | shifting and correcting, 16 iterations
  // S_DONE  | one-cycle done pulse; a new start may be accepted here
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_work;
  logic [4:0]  r_cnt;
  logic        r_err;
  logic [15:0] r_binary;

  logic        w_accept;
  logic        w_invalid;
  logic        w_last;
  logic [31:0] w_shift;
  logic [31:0] w_corr;

  assign w_accept  = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_invalid = CHECK_DIGITS && ((D4 > 4'd9) || (hundreds > 4'd9) ||
                                      (tens > 4'd9) || (ones > 4'd9));
  assign w_last    = (r_cnt == 5'd15);
  assign w_shift   = r_work >> 1;

  // Nibbles are corrected independently; no borrow crosses a digit boundary.
  always_comb begin
    w_corr = w_shift;
    for (int i = 0; i < 4; i++) begin
      if (w_shift[16+4*i +: 4] >= 4'd8)
        w_corr[16+4*i +: 4] = w_shift[16+4*i +: 4] - 4'd3;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = w_invalid ? S_LOAD : S_SHIFT;
      S_LOAD:  w_next = S_DONE;
      S_SHIFT: if (w_last) w_next = S_DONE;
      S_DONE:  begin
        if (start) w_next = w_invalid ? S_LOAD : S_SHIFT;
        else       w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_work   <= '0;
      r_cnt    <= '0;
      r_err    <= 1'b0;
      r_binary <= '0;
    end else if (w_accept) begin
      r_work <= {D4, hundreds, tens, ones, 16'h0000};
      r_cnt  <= '0;
      r_err  <= 1'b0;
    end else if (r_state == S_SHIFT) begin
      r_work <= w_corr;
      r_cnt  <= r_cnt + 5'd1;
      if (w_last) r_binary <= w_corr[15:0];
    end else if (r_state == S_LOAD) begin
      r_binary <= '0;
      r_err    <= 1'b1;
    end
  end

  assign busy   = (r_state == S_SHIFT) || (r_state == S_LOAD);
  assign done   = (r_state == S_DONE);
  assign err    = r_err;
  assign binary = r_binary;

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Self-checking bench for bcd_to_binary_seq: directed scenarios plus random digits
// checked against a plain decimal-arithmetic reference.
module tb_bcd_to_binary_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  D4 = '0, hundreds = '0, tens = '0, ones = '0;
  logic        busy, done, err;
  logic [15:0] binary;

  int total = 0;
  int bad   = 0;

  bcd_to_binary_seq #(.CHECK_DIGITS(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .D4(D4), .hundreds(hundreds), .tens(tens), .ones(ones),
    .busy(busy), .done(done), .err(err), .binary(binary)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  function automatic bit ref_invalid(input logic [3:0] a, b, c, d);
    return (a > 9) || (b > 9) || (c > 9) || (d > 9);
  endfunction

  function automatic logic [15:0] ref_value(input logic [3:0] a, b, c, d);
    int v;
    if (ref_invalid(a, b, c, d)) return 16'h0000;
    v = a * 1000 + b * 100 + c * 10 + d;
    return v[15:0];
  endfunction

  // Present digits with start for one accepting edge, then scramble the inputs.
  task automatic accept(input logic [3:0] a, b, c, d);
    @(negedge clk);
    start = 1'b1; D4 = a; hundreds = b; tens = c; ones = d;
    @(negedge clk);
    start = 1'b0;
    D4 = 4'($urandom); hundreds = 4'($urandom); tens = 4'($urandom); ones = 4'($urandom);
  endtask

  // Latency counted in edges after the accept edge; 0 means no done within budget.
  task automatic wait_done(output int lat, output int bcnt);
    lat = 0; bcnt = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (done) begin lat = n; break; end
      if (busy) bcnt++;
    end
  endtask

  task automatic test_reset;
    #1;
    total++;
    if ({busy, done, err, binary} !== 19'h0) begin
      bad++; $display("FAIL reset_hold: busy/done/err/binary=%b/%b/%b/%h required 0/0/0/0000", busy, done, err, binary);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({busy, done, err, binary} !== 19'h0) begin
      bad++; $display("FAIL reset_release: busy/done/err/binary=%b/%b/%b/%h required 0/0/0/0000", busy, done, err, binary);
    end
  endtask

  task automatic test_directed;
    logic [3:0] vec [3][4];
    int lat, bcnt;
    vec[0] = '{4'd1, 4'd2, 4'd3, 4'd4};
    vec[1] = '{4'd9, 4'd9, 4'd9, 4'd9};
    vec[2] = '{4'd0, 4'd0, 4'd0, 4'd0};
    for (int i = 0; i < 3; i++) begin
      logic [15:0] exp_v;
      exp_v = ref_value(vec[i][0], vec[i][1], vec[i][2], vec[i][3]);
      accept(vec[i][0], vec[i][1], vec[i][2], vec[i][3]);
      total++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        bad++; $display("FAIL dir%0d_start: busy=%b done=%b required busy=1 done=0", i, busy, done);
      end
      wait_done(lat, bcnt);
      total++;
      if (lat !== 16) begin bad++; $display("FAIL dir%0d_latency: got %0d required 16", i, lat); end
      total++;
      if (bcnt !== 15) begin bad++; $display("FAIL dir%0d_busy: busy cycles %0d required 15", i, bcnt); end
      total++;
      if (binary !== exp_v || err !== 1'b0 || busy !== 1'b0) begin
        bad++; $display("FAIL dir%0d_result: binary=%h err=%b busy=%b required %h 0 0", i, binary, err, busy, exp_v);
      end
      @(negedge clk);
      total++;
      if (done !== 1'b0 || binary !== exp_v) begin
        bad++; $display("FAIL dir%0d_pulse: done=%b binary=%h required 0 %h", i, done, binary, exp_v);
      end
    end
  endtask

  task automatic test_invalid;
    int lat, bcnt;
    accept(4'd0, 4'd0, 4'hA, 4'd5);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL inv_busy: busy=%b required 1", busy); end
    wait_done(lat, bcnt);
    total++;
    if (lat !== 1 || err !== 1'b1 || binary !== 16'h0000 || busy !== 1'b0) begin
      bad++; $display("FAIL inv_result: lat=%0d err=%b binary=%h busy=%b required 1 1 0000 0", lat, err, binary, busy);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0 || err !== 1'b1) begin
      bad++; $display("FAIL inv_hold: done=%b err=%b required 0 1", done, err);
    end
    accept(4'd0, 4'd0, 4'd0, 4'd7);
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL inv_err_clear: err=%b required 0", err); end
    wait_done(lat, bcnt);
    total++;
    if (lat !== 16 || binary !== 16'h0007 || err !== 1'b0) begin
      bad++; $display("FAIL inv_recover: lat=%0d binary=%h err=%b required 16 0007 0", lat, binary, err);
    end
  endtask

  task automatic test_ignore_start;
    int lat, bcnt, extra;
    accept(4'd1, 4'd2, 4'd3, 4'd4);
    repeat (4) @(negedge clk);
    start = 1'b1; D4 = 4'd8; hundreds = 4'd8; tens = 4'd8; ones = 4'd8;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bcnt);
    total++;
    if (lat !== 11 || binary !== 16'h04D2 || err !== 1'b0) begin
      bad++; $display("FAIL ignore_result: lat=%0d binary=%h err=%b required 11 04d2 0", lat, binary, err);
    end
    extra = 0;
    repeat (20) begin @(negedge clk); if (done || busy) extra++; end
    total++;
    if (extra !== 0) begin bad++; $display("FAIL ignore_queued: activity cycles %0d required 0", extra); end
  endtask

  task automatic test_back_to_back;
    int lat, bcnt;
    accept(4'd1, 4'd2, 4'd3, 4'd4);
    repeat (15) @(negedge clk);
    start = 1'b1; D4 = 4'd0; hundreds = 4'd5; tens = 4'd0; ones = 4'd0;
    @(negedge clk);
    total++;
    if (done !== 1'b1 || binary !== 16'h04D2) begin
      bad++; $display("FAIL b2b_first: done=%b binary=%h required 1 04d2", done, binary);
    end
    @(negedge clk);
    start = 1'b0;
    total++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL b2b_accept: done=%b busy=%b required 0 1", done, busy);
    end
    wait_done(lat, bcnt);
    total++;
    if (lat !== 16 || binary !== 16'h01F4 || err !== 1'b0) begin
      bad++; $display("FAIL b2b_second: lat=%0d binary=%h err=%b required 16 01f4 0", lat, binary, err);
    end
  endtask

  task automatic test_random;
    int lat, bcnt;
    for (int i = 0; i < 25; i++) begin
      logic [3:0] a, b, c, d;
      logic [15:0] exp_v;
      bit inv;
      a = 4'($urandom_range(0, 10)); b = 4'($urandom_range(0, 9));
      c = 4'($urandom_range(0, 9));  d = 4'($urandom_range(0, 10));
      inv = ref_invalid(a, b, c, d);
      exp_v = ref_value(a, b, c, d);
      accept(a, b, c, d);
      wait_done(lat, bcnt);
      total++;
      if (lat !== (inv ? 1 : 16) || binary !== exp_v || err !== inv) begin
        bad++; $display("FAIL rand%0d %0d%0d%0d%0d: lat=%0d binary=%h err=%b required %0d %h %b",
                        i, a, b, c, d, lat, binary, err, inv ? 1 : 16, exp_v, inv);
      end
    end
  endtask

  task automatic test_reset_mid;
    int hits;
    accept(4'd1, 4'd2, 4'd3, 4'd4);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy, done, err, binary} !== 19'h0) begin
      bad++; $display("FAIL midreset_clear: busy/done/err/binary=%b/%b/%b/%h required 0/0/0/0000", busy, done, err, binary);
    end
    @(negedge clk);
    rst_n = 1'b1;
    hits = 0;
    repeat (25) begin @(negedge clk); if (done || busy) hits++; end
    total++;
    if (hits !== 0) begin bad++; $display("FAIL midreset_quiet: activity cycles %0d required 0", hits); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_invalid();
    test_ignore_start();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
